// File: rtl/latch_bank_wr_arbiter.sv
// Round-robin write arbiter and setup/enable/hold sequencer for a shared d_latch bank,
// with a one-cycle bank clear on request. Every output is registered.
module latch_bank_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic                     clr_req,
    output logic [NREQ-1:0]          ack,
    output logic                     clr_ack,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [DW-1:0]            lat_d,
    output logic                     lat_en,
    output logic                     lat_rst_n
);
    // state  | meaning
    // IDLE   | arbitrate; clear request wins over writes
    // SETUP  | data on lat_d, enable still low
    // ENABLE | lat_en high for EN_CYCLES cycles
    // HOLD   | enable low, data held, ack to the granted requester
    // CLEAR  | lat_rst_n low for one cycle, clr_ack
    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, CLEAR} state_t;

    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;
    localparam logic [3:0]    EN_LOAD = 4'(EN_CYCLES - 1);
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [3:0]      en_cnt;
    logic            mask_last;
    logic            mask_clr;
    logic [NREQ-1:0] eligible;
    logic            found;
    logic [IW-1:0]   pick;
    logic [SW-1:0]   scan;
    logic [IW-1:0]   cand;
    logic [DW-1:0]   data_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // The requester acked in the previous cycle may still show req high; ignore it once.
    always_comb begin
        eligible = req;
        if (mask_last) begin
            eligible[gnt_id] = 1'b0;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + SW'(i);
            if (scan >= SW'(NREQ)) begin
                scan = scan - SW'(NREQ);
            end
            cand = scan[IW-1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            en_cnt    <= '0;
            mask_last <= 1'b0;
            mask_clr  <= 1'b0;
            ack       <= '0;
            clr_ack   <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= '0;
            lat_d     <= '0;
            lat_en    <= 1'b0;
            lat_rst_n <= 1'b0;
        end else begin
            ack       <= '0;
            clr_ack   <= 1'b0;
            lat_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    mask_clr  <= 1'b0;
                    lat_en    <= 1'b0;
                    if (clr_req && !mask_clr) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        clr_ack   <= 1'b1;
                        lat_rst_n <= 1'b0;
                    end else if (found) begin
                        state  <= SETUP;
                        busy   <= 1'b1;
                        gnt_id <= pick;
                        lat_d  <= data_arr[pick];
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETUP: begin
                    state  <= ENABLE;
                    lat_en <= 1'b1;
                    en_cnt <= EN_LOAD;
                end
                ENABLE: begin
                    if (en_cnt == 4'd0) begin
                        state  <= HOLD;
                        lat_en <= 1'b0;
                        ack    <= NREQ'(1) << gnt_id;
                    end else begin
                        en_cnt <= en_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mask_last <= 1'b1;
                    rr_ptr    <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                end
                CLEAR: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mask_clr <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    lat_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_latch_bank_wr_arbiter.sv
// Bench for latch_bank_wr_arbiter: directed vectors and sequences plus random traffic
// checked every cycle against a transaction-timeline reference model.
module tb_latch_bank_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int EN   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               clr_req;
    logic [NREQ-1:0]    ack;
    logic               clr_ack, busy;
    logic [1:0]         gnt_id;
    logic [DW-1:0]      lat_d;
    logic               lat_en, lat_rst_n;

    logic [1:0]      req2;
    logic [2*DW-1:0] req_data2;
    logic            clr_req2;
    logic [1:0]      ack2;
    logic            clr_ack2, busy2;
    logic            gnt_id2;
    logic [DW-1:0]   lat_d2;
    logic            lat_en2, lat_rst_n2;

    latch_bank_wr_arbiter #(.NREQ(4), .DW(8), .EN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr_req(clr_req),
        .ack(ack), .clr_ack(clr_ack), .busy(busy), .gnt_id(gnt_id),
        .lat_d(lat_d), .lat_en(lat_en), .lat_rst_n(lat_rst_n)
    );

    latch_bank_wr_arbiter #(.NREQ(2), .DW(8), .EN_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .clr_req(clr_req2),
        .ack(ack2), .clr_ack(clr_ack2), .busy(busy2), .gnt_id(gnt_id2),
        .lat_d(lat_d2), .lat_en(lat_en2), .lat_rst_n(lat_rst_n2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: position within the current transaction (0 = idle).
    // A write occupies positions 1..EN+2 (setup, enable x EN, hold); a clear occupies 1.
    int              m_phase, m_last, m_ptr;
    bit              m_is_clr, m_mask_last, m_mask_clr, m_post_rst;
    logic [DW-1:0]   m_data;

    function automatic void model_reset();
        m_phase     = 0;
        m_last      = 0;
        m_ptr       = 0;
        m_is_clr    = 0;
        m_mask_last = 0;
        m_mask_clr  = 0;
        m_post_rst  = 1;
        m_data      = '0;
    endfunction

    function automatic void model_update();
        logic [NREQ-1:0] elig;
        bit              clr_ok;
        bit              got;
        int              c;
        if (m_phase == 0) begin
            elig = req;
            if (m_mask_last) elig = elig & ~(4'(1) << m_last);
            clr_ok      = clr_req && !m_mask_clr;
            m_mask_last = 0;
            m_mask_clr  = 0;
            if (clr_ok) begin
                m_is_clr = 1;
                m_phase  = 1;
            end else if (elig != '0) begin
                got = 0;
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (!got && (((elig >> c) & 4'b0001) != 4'b0000)) begin
                        got    = 1;
                        m_last = c;
                    end
                end
                m_data  = DW'(req_data >> (m_last * DW));
                m_phase = 1;
            end
        end else if (m_is_clr) begin
            m_phase    = 0;
            m_is_clr   = 0;
            m_mask_clr = 1;
        end else if (m_phase == EN + 2) begin
            m_phase     = 0;
            m_mask_last = 1;
            m_ptr       = (m_last + 1) % NREQ;
        end else begin
            m_phase++;
        end
        m_post_rst = 0;
    endfunction

    task automatic model_check();
        bit wr;
        wr = (m_phase != 0) && !m_is_clr;
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("lat_en",    32'(lat_en),    32'(wr && m_phase >= 2 && m_phase <= EN + 1));
        chk("ack",       32'(ack),       (wr && m_phase == EN + 2) ? (32'd1 << m_last) : 32'd0);
        chk("clr_ack",   32'(clr_ack),   32'(m_is_clr));
        chk("lat_rst_n", 32'(lat_rst_n), 32'(!m_post_rst && !m_is_clr));
        chk("gnt_id",    32'(gnt_id),    32'(m_last));
        chk("lat_d",     32'(lat_d),     32'(m_data));
        chk("en_vs_rst", 32'(lat_en && !lat_rst_n), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        #1;
        model_check();
    endtask

    // Called 1 time unit after a rising edge; asserts reset between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_lat_en",    32'(lat_en),    32'd0);
        chk("rst_async_lat_rst_n", 32'(lat_rst_n), 32'd0);
        chk("rst_async_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_check();
    endtask

    task automatic wait_ack(output int idx, output int steps, output int en_seen);
        idx     = -1;
        steps   = 0;
        en_seen = 0;
        while (idx < 0 && steps < 40) begin
            step();
            steps++;
            if (lat_en) en_seen++;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) idx = i;
            end
        end
        chk("ack_seen", 32'(idx >= 0), 32'd1);
    endtask

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*DW-1:0] data;
        int                 exp_gnt;
        logic [DW-1:0]      exp_d;
    } vec_t;

    vec_t vecs [5];
    int   exp_rr [5];
    int   idx, n, en_n;
    int   idx2, n2, en2;

    initial begin
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h0000_2211, 0, 8'h11};
        vecs[2] = '{4'b1001, 32'h4400_0033, 3, 8'h44};
        vecs[3] = '{4'b0110, 32'h0066_5500, 1, 8'h55};
        vecs[4] = '{4'b0001, 32'h0000_0077, 0, 8'h77};
        exp_rr  = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        clr_req   = 1'b0;
        req2      = '0;
        req_data2 = '0;
        clr_req2  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_check();
        chk("init_lat_rst_n_low", 32'(lat_rst_n), 32'd0);

        // Reset in the middle of ENABLE, then round-robin from req0.
        req      = 4'b1000;
        req_data = 32'h9900_0000;
        step();
        step();
        chk("pre_rst_lat_en", 32'(lat_en), 32'd1);
        do_reset();
        req      = 4'b1111;
        req_data = 32'h4433_2211;
        step();
        chk("rst_release_lat_rst_n", 32'(lat_rst_n), 32'd1);
        for (int g = 0; g < 5; g++) begin
            wait_ack(idx, n, en_n);
            chk("rr_order", 32'(idx), 32'(exp_rr[g]));
            chk("rr_lat_d", 32'(lat_d), 32'((exp_rr[g] + 1) * 8'h11));
        end
        req = '0;
        step();
        chk("rr_ack_one_cycle", 32'(ack), 32'd0);
        step();

        // Table of single writes; rr pointer is 1 on entry.
        for (int v = 0; v < 5; v++) begin
            req      = vecs[v].req;
            req_data = vecs[v].data;
            step();
            chk("setup_lat_d",  32'(lat_d),  32'(vecs[v].exp_d));
            chk("setup_gnt_id", 32'(gnt_id), 32'(vecs[v].exp_gnt));
            chk("setup_lat_en", 32'(lat_en), 32'd0);
            wait_ack(idx, n, en_n);
            chk("vec_ack_id",    32'(idx),      32'(vecs[v].exp_gnt));
            chk("vec_latency",   32'(n + 1),    32'(EN + 2));
            chk("vec_en_cycles", 32'(en_n),     32'(EN));
            chk("vec_hold_d",    32'(lat_d),    32'(vecs[v].exp_d));
            req = '0;
            step();
            chk("vec_ack_one_cycle", 32'(ack), 32'd0);
            step();
        end

        // Clear takes priority; clr_req held over the following IDLE is masked.
        do_reset();
        clr_req  = 1'b1;
        req      = 4'b0011;
        req_data = 32'h0000_2211;
        step();
        chk("clr_ack",       32'(clr_ack),   32'd1);
        chk("clr_lat_rst_n", 32'(lat_rst_n), 32'd0);
        chk("clr_lat_en",    32'(lat_en),    32'd0);
        step();
        chk("clr_ack_one_cycle",  32'(clr_ack),   32'd0);
        chk("clr_rst_n_released", 32'(lat_rst_n), 32'd1);
        step();
        chk("after_clr_gnt", 32'(gnt_id),  32'd0);
        chk("after_clr_busy", 32'(busy),   32'd1);
        chk("after_clr_no_reclear", 32'(clr_ack), 32'd0);
        clr_req = 1'b0;
        wait_ack(idx, n, en_n);
        chk("after_clr_ack_id", 32'(idx), 32'd0);
        req = '0;
        step();
        step();

        // Hold-over mask, re-request, and request dropped during ENABLE.
        req      = 4'b0001;
        req_data = 32'h0000_005A;
        wait_ack(idx, n, en_n);
        step();
        step();
        chk("mask_no_regrant", 32'(busy), 32'd0);
        req = '0;
        step();
        chk("mask_still_idle", 32'(busy), 32'd0);
        req = 4'b0001;
        wait_ack(idx, n, en_n);
        chk("regrant_id", 32'(idx), 32'd0);
        req = '0;
        step();
        step();
        req      = 4'b0100;
        req_data = 32'h00C6_0000;
        step();
        step();
        req = '0;
        wait_ack(idx, n, en_n);
        chk("dropped_req_ack", 32'(idx), 32'd2);
        step();
        step();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            clr_req  = ($urandom_range(0, 7) == 0);
            req_data = $urandom;
            step();
        end
        req     = '0;
        clr_req = 1'b0;

        // NREQ=2, EN_CYCLES=1 build: single enable cycle and 1 -> 0 wrap.
        req_data2 = 16'h3CC3;
        req2      = 2'b11;
        for (int g = 0; g < 3; g++) begin
            idx2 = -1;
            n2   = 0;
            en2  = 0;
            while (idx2 < 0 && n2 < 20) begin
                step();
                n2++;
                if (lat_en2) en2++;
                if (ack2[0]) idx2 = 0;
                else if (ack2[1]) idx2 = 1;
            end
            chk("dut2_ack_seen",  32'(idx2 >= 0), 32'd1);
            chk("dut2_rr",        32'(idx2),      32'(g % 2));
            chk("dut2_en_cycles", 32'(en2),       32'd1);
            chk("dut2_latency",   32'(n2),        (g == 0) ? 32'd3 : 32'd4);
            chk("dut2_lat_d",     32'(lat_d2),    (g % 2 == 1) ? 32'h3C : 32'hC3);
        end
        req2 = '0;
        step();
        chk("dut2_ack_one_cycle", 32'(ack2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
